// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes and the multiply/divide sequencer state encoding.
// Pure declarations; no logic, no latency, no flow control.
package cpu_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_ADD  = 4'd0;
    localparam alu_op_t ALU_SUB  = 4'd1;
    localparam alu_op_t ALU_ADC  = 4'd2;
    localparam alu_op_t ALU_SBC  = 4'd3;
    localparam alu_op_t ALU_NOT  = 4'd4;
    localparam alu_op_t ALU_AND  = 4'd5;
    localparam alu_op_t ALU_OR   = 4'd6;
    localparam alu_op_t ALU_XOR  = 4'd7;
    localparam alu_op_t ALU_SHL  = 4'd8;
    localparam alu_op_t ALU_SHR  = 4'd9;
    localparam alu_op_t ALU_ASL  = 4'd10;
    localparam alu_op_t ALU_ASR  = 4'd11;
    localparam alu_op_t ALU_SL4  = 4'd12;
    localparam alu_op_t ALU_SL16 = 4'd13;
    localparam alu_op_t ALU_SR4  = 4'd14;
    localparam alu_op_t ALU_SR16 = 4'd15;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_t;

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/result bus of the multiply/divide sequencer plus its borrowed ALU port.
// slave = the sequencer, master = the requester that also hosts the ALU.
interface muldiv_seq_if;

    logic                 start;
    logic                 mode;
    logic [31:0]          a;
    logic [31:0]          b;
    logic                 busy;
    logic                 done;
    logic [31:0]          res_lo;
    logic [31:0]          res_hi;
    cpu_pkg::alu_op_t     alu_op;
    logic [31:0]          alu_a;
    logic [31:0]          alu_b;
    logic                 alu_cin;
    logic [31:0]          alu_result;
    logic                 alu_c;

    modport slave (
        input  start, mode, a, b, alu_result, alu_c,
        output busy, done, res_lo, res_hi, alu_op, alu_a, alu_b, alu_cin
    );

    modport master (
        output start, mode, a, b, alu_result, alu_c,
        input  busy, done, res_lo, res_hi, alu_op, alu_a, alu_b, alu_cin
    );

endinterface

// File: rtl/muldiv_seq.sv
// Iterative 32-bit MUL (shift-add) / DIVU (restoring) using the external ALU, one op per cycle.
// MUL: msb(b)+2 cycles, DIVU: 33 cycles, b==0: 1 cycle; start is ignored while busy.
module muldiv_seq
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    muldiv_seq_if.slave bus
);

    md_state_t   state;
    logic [31:0] acc;      // product accumulator (MUL) / partial remainder (DIV)
    logic [31:0] mcand;
    logic [31:0] mplier;   // multiplier (MUL) / dividend-becoming-quotient (DIV)
    logic [4:0]  cnt;

    logic [31:0] mul_acc;
    logic [31:0] mcand_sh;
    logic [31:0] mplier_sh;
    logic        sub_ok;
    logic [31:0] rem_nxt;
    logic [31:0] quot_nxt;

    always_comb begin
        mul_acc   = mplier[0] ? bus.alu_result : acc;
        mcand_sh  = {mcand[30:0], 1'b0};
        mplier_sh = {1'b0, mplier[31:1]};
        // A set remainder msb means the shifted value is >= 2^32, so it always exceeds the divisor.
        sub_ok    = acc[31] | ~bus.alu_c;
        rem_nxt   = sub_ok ? bus.alu_result : {acc[30:0], mplier[31]};
        quot_nxt  = {mplier[30:0], sub_ok};
    end

    assign bus.alu_cin = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= MD_IDLE;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            cnt        <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.res_lo <= '0;
            bus.res_hi <= '0;
            bus.alu_op <= ALU_ADD;
            bus.alu_a  <= '0;
            bus.alu_b  <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                MD_IDLE, MD_DONE: begin
                    state <= MD_IDLE;
                    if (bus.start) begin
                        acc    <= '0;
                        mcand  <= bus.a;
                        mplier <= bus.mode ? bus.a : bus.b;
                        cnt    <= '0;
                        if (bus.b == 32'd0) begin
                            state      <= MD_DONE;
                            bus.done   <= 1'b1;
                            bus.res_lo <= bus.mode ? 32'hFFFF_FFFF : 32'd0;
                            bus.res_hi <= bus.mode ? bus.a : 32'd0;
                        end else if (bus.mode) begin
                            state      <= MD_DIV;
                            bus.busy   <= 1'b1;
                            bus.alu_op <= ALU_SUB;
                            bus.alu_a  <= {31'd0, bus.a[31]};
                            bus.alu_b  <= bus.b;
                        end else begin
                            state      <= MD_MUL;
                            bus.busy   <= 1'b1;
                            bus.alu_op <= ALU_ADD;
                            bus.alu_a  <= '0;
                            bus.alu_b  <= bus.a;
                        end
                    end
                end
                MD_MUL: begin
                    acc    <= mul_acc;
                    mcand  <= mcand_sh;
                    mplier <= mplier_sh;
                    if (mplier_sh == 32'd0) begin
                        state      <= MD_DONE;
                        bus.busy   <= 1'b0;
                        bus.done   <= 1'b1;
                        bus.res_lo <= mul_acc;
                        bus.res_hi <= '0;
                        bus.alu_op <= ALU_ADD;
                        bus.alu_a  <= '0;
                        bus.alu_b  <= '0;
                    end else begin
                        bus.alu_a  <= mul_acc;
                        bus.alu_b  <= mcand_sh;
                    end
                end
                MD_DIV: begin
                    acc    <= rem_nxt;
                    mplier <= quot_nxt;
                    cnt    <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state      <= MD_DONE;
                        bus.busy   <= 1'b0;
                        bus.done   <= 1'b1;
                        bus.res_lo <= quot_nxt;
                        bus.res_hi <= rem_nxt;
                        bus.alu_op <= ALU_ADD;
                        bus.alu_a  <= '0;
                        bus.alu_b  <= '0;
                    end else begin
                        // alu_b keeps the divisor for the whole division.
                        bus.alu_a  <= {rem_nxt[30:0], quot_nxt[31]};
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq with a behavioural ADD/SUB ALU beside it; vector table plus corner sequences.
module tb_muldiv_seq;
    import cpu_pkg::*;

    typedef struct packed {
        logic        m;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [7:0]  lat;
    } vec_t;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
    } exp_t;

    logic clk;
    logic rst;
    muldiv_seq_if bus();

    muldiv_seq dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // ALU stand-in: bit 32 is carry for ADD and borrow for SUB.
    logic [32:0] alu_sum;
    always_comb begin
        if (bus.alu_op == ALU_SUB)
            alu_sum = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
        else
            alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {32'd0, bus.alu_cin};
    end
    assign bus.alu_result = alu_sum[31:0];
    assign bus.alu_c      = alu_sum[32];

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];
    vec_t tbl[0:10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic m, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        if (m) begin
            if (y == 32'd0) begin
                e.lo = 32'hFFFF_FFFF;
                e.hi = x;
            end else begin
                e.lo = x / y;
                e.hi = x % y;
            end
        end else begin
            e.lo = x * y;
            e.hi = 32'd0;
        end
        return e;
    endfunction

    function automatic int model_lat(input logic m, input logic [31:0] y);
        if (y == 32'd0) return 1;
        if (m) return 33;
        for (int i = 31; i >= 0; i--)
            if (y[i]) return i + 2;
        return 1;
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no result pending");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("res_lo", bus.res_lo, e.lo);
                check("res_hi", bus.res_hi, e.hi);
            end
        end
    end

    task automatic run_op(input logic m, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] lo, input logic [31:0] hi,
                          input int lat, input int pulse_at);
        int   n;
        bit   seen_busy;
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1; bus.mode = m; bus.a = x; bus.b = y;
        e.lo = lo; e.hi = hi;
        sb_q.push_back(e);
        @(posedge clk); #1;
        // scramble operands so any late re-sampling shows up in the result
        bus.start = 1'b0; bus.mode = ~m; bus.a = $urandom; bus.b = $urandom;
        n = 1;
        seen_busy = 1'b0;
        while (!bus.done && n < 200) begin
            if (bus.busy) seen_busy = 1'b1;
            bus.start = (n == pulse_at);
            @(posedge clk); #1;
            n++;
        end
        bus.start = 1'b0;
        check("latency", 32'(n), 32'(lat));
        check("busy_seen", 32'(seen_busy), 32'(lat > 1));
        @(posedge clk); #1;
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("idle_not_busy", 32'(bus.busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},   32'(bus.busy), 32'd0);
        check({tag, "_done"},   32'(bus.done), 32'd0);
        check({tag, "_res_lo"}, bus.res_lo, 32'd0);
        check({tag, "_res_hi"}, bus.res_hi, 32'd0);
        check({tag, "_alu_op"}, 32'(bus.alu_op), 32'(ALU_ADD));
        check({tag, "_alu_a"},  bus.alu_a, 32'd0);
        check({tag, "_alu_b"},  bus.alu_b, 32'd0);
        check({tag, "_alu_cin"}, 32'(bus.alu_cin), 32'd0);
    endtask

    initial begin
        int   n;
        exp_t e;
        logic m;
        logic [31:0] x;
        logic [31:0] y;

        clk = 1'b0; rst = 1'b1;
        bus.start = 1'b0; bus.mode = 1'b0; bus.a = '0; bus.b = '0;

        tbl[0]  = '{1'b0, 32'd7,          32'd6,          32'd42,         32'd0,  8'd4};
        tbl[1]  = '{1'b0, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFF,  32'd0,  8'd33};
        tbl[2]  = '{1'b1, 32'd100,        32'd7,          32'd14,         32'd2,  8'd33};
        tbl[3]  = '{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          32'd1,  8'd33};
        tbl[4]  = '{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,  8'd1};
        tbl[5]  = '{1'b0, 32'd12345,      32'd0,          32'd0,          32'd0,  8'd1};
        tbl[6]  = '{1'b0, 32'h0000_1234,  32'd1,          32'h0000_1234,  32'd0,  8'd2};
        tbl[7]  = '{1'b1, 32'd3,          32'd10,         32'd0,          32'd3,  8'd33};
        tbl[8]  = '{1'b1, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,  8'd33};
        tbl[9]  = '{1'b0, 32'h0001_0000,  32'h0001_0000,  32'd0,          32'd0,  8'd18};
        tbl[10] = '{1'b1, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,  8'd33};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");

        for (int i = 0; i <= 10; i++)
            run_op(tbl[i].m, tbl[i].a, tbl[i].b, tbl[i].lo, tbl[i].hi, int'(tbl[i].lat), 0);

        for (int i = 0; i < 6; i++) begin
            m = 1'($urandom_range(0, 1));
            x = $urandom;
            y = $urandom >> $urandom_range(0, 31);
            e = model(m, x, y);
            run_op(m, x, y, e.lo, e.hi, model_lat(m, y), 0);
        end

        // Start pulse in cycle 10 of a division must be ignored.
        run_op(1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 33, 10);

        // Back-to-back: start held, the next request is taken in the DONE cycle.
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 1'b1; bus.a = 32'd9; bus.b = 32'd3;
        e.lo = 32'd3; e.hi = 32'd0; sb_q.push_back(e);
        @(posedge clk); #1;
        bus.mode = 1'b0; bus.a = 32'd5; bus.b = 32'd3;
        e.lo = 32'd15; e.hi = 32'd0; sb_q.push_back(e);
        n = 1;
        while (!bus.done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_div_latency", 32'(n), 32'd33);
        @(posedge clk); #1;
        n++;
        bus.start = 1'b0;
        check("b2b_second_busy", 32'(bus.busy), 32'd1);
        while (!bus.done && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_mul_done_cycle", 32'(n), 32'd36);
        @(posedge clk); #1;
        check("b2b_done_one_cycle", 32'(bus.done), 32'd0);

        // Reset in cycle 15 of a division: back to IDLE with reset outputs and no done.
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 1'b1; bus.a = 32'd1000; bus.b = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check("mid_div_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_outputs("mid_rst");
        repeat (40) @(posedge clk);
        #1;
        check("post_rst_idle", 32'(bus.busy), 32'd0);
        run_op(1'b0, 32'd3, 32'd3, 32'd9, 32'd0, 3, 0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
